beta_muldiv_unit: RTL and testbench

Multicycle signed multiply/divide unit for the Beta execute stage. It takes the same operand bus (ALU_OP, DATA_X, DATA_Y) as the combinational ALU and services the two opcodes the ALU returns zero for: MUTL (4'b0010) and DIV (4'b0011). Its registered result feeds the execute-stage result mux alongside ALU_OUT. It uses a START/BUSY/DONE handshake so the pipeline control can stall while an operation is in flight.

---
 rtl/beta_muldiv_unit_if.sv | 25 ++
 rtl/beta_muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_beta_muldiv_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/beta_muldiv_unit_if.sv
// Operand/handshake bundle between the Beta execute stage and the
// multicycle multiply/divide unit.
interface beta_muldiv_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
);
    logic                  start;
    logic [OP_WIDTH-1:0]   alu_op;
    logic [DATA_WIDTH-1:0] data_x;
    logic [DATA_WIDTH-1:0] data_y;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] md_out;
    logic                  div_zero;

    modport master (
        output start, alu_op, data_x, data_y,
        input  busy, done, md_out, div_zero
    );

    modport slave (
        input  start, alu_op, data_x, data_y,
        output busy, done, md_out, div_zero
    );
endinterface

// File: rtl/beta_muldiv_unit.sv
// Multicycle signed multiply (shift-add) / divide (restoring) unit.
// Optional feature macro: BETA_MD_ZERO_SKIP_EN -- zero operands bypass
// the 32-iteration loop and finish with the divide-by-zero latency.
//
// state | meaning
// IDLE  | waiting for START with MUTL or DIV
// MUL   | shift-add iterations, multiplier LSB first
// DIV   | restoring iterations on magnitudes, quotient MSB first
// FIN   | one-cycle DONE; result registers were written on entry
module beta_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input logic                clk,
    input logic                rst_n,
    beta_muldiv_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [OP_WIDTH-1:0] OP_MUTL = OP_WIDTH'(4'b0010);
    localparam logic [OP_WIDTH-1:0] OP_DIV  = OP_WIDTH'(4'b0011);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] opa, opa_nx;     // multiplicand / dividend -> quotient
    logic [DATA_WIDTH-1:0] opb, opb_nx;     // multiplier / divisor magnitude
    logic [DATA_WIDTH-1:0] acc, acc_nx;     // partial product / remainder
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic                  neg, neg_nx;
    logic                  dz, dz_nx;
    logic                  skip, skip_nx;
    logic                  busy_r, busy_nx;
    logic                  done_r, done_nx;
    logic [DATA_WIDTH-1:0] md_r, md_nx;
    logic                  dzo_r, dzo_nx;

    logic                  is_mul, is_div, skip_accept;
    logic [DATA_WIDTH-1:0] prod, quot;
    logic [DATA_WIDTH:0]   shifted;
    logic                  ge;

    assign is_mul = (bus.alu_op == OP_MUTL);
    assign is_div = (bus.alu_op == OP_DIV);

`ifdef BETA_MD_ZERO_SKIP_EN
    assign skip_accept = is_mul ? ((bus.data_x == '0) || (bus.data_y == '0))
                                : ((bus.data_x == '0) && (bus.data_y != '0));
`else
    assign skip_accept = 1'b0;
`endif

    // One datapath step of each algorithm, evaluated from the current registers
    assign prod    = acc + (opb[0] ? opa : '0);
    assign shifted = {acc, opa[DATA_WIDTH-1]};
    assign ge      = (shifted >= {1'b0, opb});
    assign quot    = {opa[DATA_WIDTH-2:0], ge};

    // Next-state and datapath update; every target defaults to hold
    always_comb begin
        state_nx = state;
        opa_nx   = opa;
        opb_nx   = opb;
        acc_nx   = acc;
        cnt_nx   = cnt;
        neg_nx   = neg;
        dz_nx    = dz;
        skip_nx  = skip;
        md_nx    = md_r;
        dzo_nx   = dzo_r;
        case (state)
            IDLE: begin
                if (bus.start && (is_mul || is_div)) begin
                    cnt_nx  = '0;
                    acc_nx  = '0;
                    skip_nx = skip_accept;
                    dz_nx   = is_div && (bus.data_y == '0);
                    neg_nx  = bus.data_x[DATA_WIDTH-1] ^ bus.data_y[DATA_WIDTH-1];
                    if (is_mul) begin
                        opa_nx   = bus.data_x;
                        opb_nx   = bus.data_y;
                        state_nx = MUL;
                    end else begin
                        opa_nx   = bus.data_x[DATA_WIDTH-1] ? ('0 - bus.data_x) : bus.data_x;
                        opb_nx   = bus.data_y[DATA_WIDTH-1] ? ('0 - bus.data_y) : bus.data_y;
                        state_nx = DIV;
                    end
                end
            end
            MUL: begin
                if (skip) begin
                    md_nx    = '0;
                    dzo_nx   = 1'b0;
                    state_nx = FIN;
                end else begin
                    acc_nx = prod;
                    opa_nx = {opa[DATA_WIDTH-2:0], 1'b0};
                    opb_nx = {1'b0, opb[DATA_WIDTH-1:1]};
                    cnt_nx = cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        md_nx    = prod;
                        dzo_nx   = 1'b0;
                        state_nx = FIN;
                    end
                end
            end
            DIV: begin
                if (dz) begin
                    md_nx    = '1;
                    dzo_nx   = 1'b1;
                    state_nx = FIN;
                end else if (skip) begin
                    md_nx    = '0;
                    dzo_nx   = 1'b0;
                    state_nx = FIN;
                end else begin
                    // Remainder stays below the divisor, so W-bit wraparound is exact
                    acc_nx = ge ? (shifted[DATA_WIDTH-1:0] - opb) : shifted[DATA_WIDTH-1:0];
                    opa_nx = quot;
                    cnt_nx = cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        md_nx    = neg ? ('0 - quot) : quot;
                        dzo_nx   = 1'b0;
                        state_nx = FIN;
                    end
                end
            end
            FIN: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx == MUL) || (state_nx == DIV);
        done_nx = (state_nx == FIN);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            dz     <= 1'b0;
            skip   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            md_r   <= '0;
            dzo_r  <= 1'b0;
        end else begin
            opa    <= opa_nx;
            opb    <= opb_nx;
            acc    <= acc_nx;
            cnt    <= cnt_nx;
            neg    <= neg_nx;
            dz     <= dz_nx;
            skip   <= skip_nx;
            busy_r <= busy_nx;
            done_r <= done_nx;
            md_r   <= md_nx;
            dzo_r  <= dzo_nx;
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.md_out   = md_r;
    assign bus.div_zero = dzo_r;
endmodule

// File: tb/tb_beta_muldiv_unit.sv
// Bench for beta_muldiv_unit: timeline model compared every cycle, plus
// directed operations with hand-computed results and latencies.
module tb_beta_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    beta_muldiv_unit_if #(.DATA_WIDTH(32), .OP_WIDTH(4)) bus ();
    beta_muldiv_unit #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

`ifdef BETA_MD_ZERO_SKIP_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 33;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: an accepted op finishes a fixed number of edges later
    int          edge_n = 0;
    bit          model_live = 0;
    bit          m_active = 0;
    int          m_done_edge = 0;
    logic [31:0] m_res = '0;
    bit          m_dz = 0;
    logic [31:0] exp_md = '0;
    bit          exp_dz = 0, exp_busy = 0, exp_done = 0;

    always @(posedge clk) begin : model
        bit was_fin;
        bit short_path;
        int sx, sy;
        edge_n++;
        model_live = 1;
        was_fin  = exp_done;
        exp_done = 0;
        if (!rst_n) begin
            m_active = 0;
            exp_md   = '0;
            exp_dz   = 0;
        end else if (m_active && edge_n == m_done_edge) begin
            exp_done = 1;
            exp_md   = m_res;
            exp_dz   = m_dz;
            m_active = 0;
        end else if (!m_active && !was_fin && bus.start &&
                     (bus.alu_op == 4'b0010 || bus.alu_op == 4'b0011)) begin
            sx = bus.data_x;
            sy = bus.data_y;
            m_dz = 0;
            short_path = 0;
            if (bus.alu_op == 4'b0010) begin
                m_res = bus.data_x * bus.data_y;
`ifdef BETA_MD_ZERO_SKIP_EN
                short_path = (sx == 0) || (sy == 0);
`endif
            end else if (sy == 0) begin
                m_res = 32'hFFFF_FFFF;
                m_dz = 1;
                short_path = 1;
            end else begin
                if (bus.data_x == 32'h8000_0000 && sy == -1) m_res = 32'h8000_0000;
                else m_res = sx / sy;
`ifdef BETA_MD_ZERO_SKIP_EN
                short_path = (sx == 0);
`endif
            end
            m_done_edge = edge_n + (short_path ? 1 : 32);
            m_active = 1;
        end
        exp_busy = m_active;
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("sb_busy", {31'b0, bus.busy}, {31'b0, exp_busy});
            chk("sb_done", {31'b0, bus.done}, {31'b0, exp_done});
            chk("sb_md_out", bus.md_out, exp_md);
            chk("sb_div_zero", {31'b0, bus.div_zero}, {31'b0, exp_dz});
        end
    end

    // Issue one op; optionally inject an ignored START n cycles after accept
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] lit, input logic lit_dz,
                          input int lit_lat, input int inj);
        int n, nb;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = op; bus.data_x = x; bus.data_y = y;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1; nb = 0; seen = 0;
        while (!seen && n <= 60) begin
            if (bus.done) seen = 1;
            else begin
                nb += int'(bus.busy);
                @(negedge clk);
                n++;
                if (inj > 0) begin
                    bus.start = (n == inj);
                    if (n == inj) begin
                        bus.alu_op = 4'b0011; bus.data_x = 32'd100; bus.data_y = 32'd7;
                    end
                end
            end
        end
        bus.start = 1'b0;
        chk({name, "_done_seen"}, {31'b0, seen}, 32'd1);
        chk({name, "_latency"}, n, lit_lat);
        chk({name, "_busy_cycles"}, nb, lit_lat - 1);
        chk({name, "_md_out"}, bus.md_out, lit);
        chk({name, "_div_zero"}, {31'b0, bus.div_zero}, {31'b0, lit_dz});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, nbz;
        bus.start = 1'b0; bus.alu_op = '0; bus.data_x = '0; bus.data_y = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_md_out", bus.md_out, 32'h0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        rst_n = 1'b1;

        run_op("mul_7_m3",   4'b0010, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, 0);
        run_op("div_m7_2",   4'b0011, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 33, 0);
        run_op("div_min_m1", 4'b0011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33, 0);
        run_op("div_5_0",    4'b0011, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 2, 0);
        run_op("mul_3_4",    4'b0010, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C, 1'b0, 33, 0);

        // Non-mul/div opcode must be ignored entirely
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = 4'b0000; bus.data_x = 32'd9; bus.data_y = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        nd = 0; nbz = 0;
        repeat (6) begin
            nd  += int'(bus.done);
            nbz += int'(bus.busy);
            @(negedge clk);
        end
        chk("add_no_done", nd, 0);
        chk("add_no_busy", nbz, 0);
        chk("add_md_held", bus.md_out, 32'h0000_000C);

        run_op("mul_inject", 4'b0010, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0, 33, 10);
        run_op("div_100_m7", 4'b0011, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 33, 0);
        run_op("mul_ovf",    4'b0010, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 33, 0);
        run_op("mul_m1_m1",  4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33, 0);

        // Reset at iteration 10 of a divide: op is lost, no DONE follows
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = 4'b0011; bus.data_x = 32'd1000; bus.data_y = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("midrst_done", {31'b0, bus.done}, 32'd0);
        chk("midrst_md_out", bus.md_out, 32'h0);
        chk("midrst_div_zero", {31'b0, bus.div_zero}, 32'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            nd += int'(bus.done);
        end
        chk("midrst_no_done", nd, 0);

        run_op("mul_0_x", 4'b0010, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0, ZLAT, 0);
        run_op("div_0_5", 4'b0011, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b0, ZLAT, 0);
        run_op("div_m9_m3", 4'b0011, 32'hFFFF_FFF7, 32'hFFFF_FFFD, 32'h0000_0003, 1'b0, 33, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
